// File: rtl/rf_stack_nested_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_stack_nested_pkg
// Description : Shared sizes, types and named registers for the nested
//               level-banked register file.
// Revision    : 1.0
// ============================================================================
package rf_stack_nested_pkg;

    localparam int N_LEVELS   = 8;
    localparam int REG_WIDTH  = 32;
    localparam int N_REGS     = 32;
    localparam int PRIO_W     = $clog2(N_LEVELS);
    localparam int ADDR_W     = $clog2(N_REGS);

    typedef logic [PRIO_W-1:0]    prio_t;
    typedef logic [REG_WIDTH-1:0] reg_t;
    typedef logic [ADDR_W-1:0]    reg_addr_t;

    // x0, sp, gp and tp are shared; ra and everything above tp are banked.
    localparam logic [N_REGS-1:0] BANK_MASK = 32'hFFFF_FFE2;
    localparam reg_t              RA_INIT   = 32'hFFFF_FFFF;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd1;
    localparam reg_addr_t REG_SP   = 5'd2;

endpackage
`default_nettype wire

// File: rtl/rf_stack_nested_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_stack_nested_if
// Description : Level-control and register-port bundle between the core /
//               interrupt controller (master) and the register file (slave).
// Revision    : 1.0
// ============================================================================
interface rf_stack_nested_if
    import rf_stack_nested_pkg::*;
();
    logic      levelPush;
    prio_t     levelPushPrio;
    logic      levelPop;
    prio_t     curLevel;
    prio_t     depth;
    logic      levelErr;
    logic      writeEn;
    logic      writeRaEn;
    reg_addr_t writeAddr;
    reg_t      writeData;
    reg_addr_t readAddr1;
    reg_addr_t readAddr2;
    reg_t      readData1;
    reg_t      readData2;

    modport master (
        output levelPush, levelPushPrio, levelPop,
        output writeEn, writeRaEn, writeAddr, writeData, readAddr1, readAddr2,
        input  curLevel, depth, levelErr, readData1, readData2
    );

    modport slave (
        input  levelPush, levelPushPrio, levelPop,
        input  writeEn, writeRaEn, writeAddr, writeData, readAddr1, readAddr2,
        output curLevel, depth, levelErr, readData1, readData2
    );
endinterface
`default_nettype wire

// File: rtl/rf_stack_nested_level_stack.sv
`default_nettype none
// ============================================================================
// Module      : rf_stack_nested_level_stack
// Description : Validates push/pop requests, keeps the preemption stack and
//               signals which bank to invalidate on entry to a new level.
// Revision    : 1.0
// ============================================================================
module rf_stack_nested_level_stack
    import rf_stack_nested_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  reset,
    input  wire logic  levelPush,
    input  wire prio_t levelPushPrio,
    input  wire logic  levelPop,
    output prio_t      curLevel,
    output prio_t      depth,
    output logic       levelErr,
    output logic       inv_strobe,
    output prio_t      inv_level
);
    localparam prio_t MAX_DEPTH = prio_t'(N_LEVELS - 1);

    prio_t r_stack [N_LEVELS-1];
    logic  w_push_ok;
    logic  w_pop_ok;
    logic  w_req_err;

    // Simultaneous push and pop is treated as a malformed request.
    always_comb begin
        w_push_ok = levelPush && !levelPop && (levelPushPrio > curLevel) && (depth < MAX_DEPTH);
        w_pop_ok  = levelPop && !levelPush && (depth != '0);
        w_req_err = (levelPush || levelPop) && !w_push_ok && !w_pop_ok;
    end

    assign inv_strobe = w_push_ok;
    assign inv_level  = levelPushPrio;

    always_ff @(posedge clk) begin
        if (reset) begin
            curLevel <= '0;
            depth    <= '0;
            levelErr <= 1'b0;
        end else begin
            levelErr <= w_req_err;
            if (w_push_ok) begin
                curLevel <= levelPushPrio;
                depth    <= depth + 1'b1;
            end else if (w_pop_ok) begin
                curLevel <= r_stack[depth - 1'b1];
                depth    <= depth - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            r_stack[depth] <= curLevel;
        end
    end
endmodule
`default_nettype wire

// File: rtl/rf_stack_nested.sv
`default_nettype none
// ============================================================================
// Module      : rf_stack_nested
// Description : Register file with per-level banked registers, lazy bank
//               invalidation and a nested preemption level stack.
// Revision    : 1.0
// ============================================================================
module rf_stack_nested
    import rf_stack_nested_pkg::*;
#(
    parameter bit BYPASS = 1'b0
)(
    input  wire logic clk,
    input  wire logic reset,
    rf_stack_nested_if.slave bus
);
    prio_t w_cur_level;
    prio_t w_depth;
    logic  w_level_err;
    logic  w_inv_strobe;
    prio_t w_inv_level;

    rf_stack_nested_level_stack u_level_stack (
        .clk           (clk),
        .reset         (reset),
        .levelPush     (bus.levelPush),
        .levelPushPrio (bus.levelPushPrio),
        .levelPop      (bus.levelPop),
        .curLevel      (w_cur_level),
        .depth         (w_depth),
        .levelErr      (w_level_err),
        .inv_strobe    (w_inv_strobe),
        .inv_level     (w_inv_level)
    );

    assign bus.curLevel = w_cur_level;
    assign bus.depth    = w_depth;
    assign bus.levelErr = w_level_err;

    reg_t              r_shared [N_REGS];
    reg_t              r_bank   [N_LEVELS][N_REGS];
    logic [N_REGS-1:0] r_valid  [N_LEVELS];
    logic              w_wr_eff;
    logic              w_wr_banked;

    always_comb begin
        w_wr_eff    = bus.writeEn && (bus.writeAddr != REG_ZERO) &&
                      ((bus.writeAddr != REG_RA) || bus.writeRaEn);
        w_wr_banked = BANK_MASK[bus.writeAddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) r_shared[i] <= '0;
        end else if (w_wr_eff && !w_wr_banked) begin
            r_shared[bus.writeAddr] <= bus.writeData;
        end
    end

    // Writes land in the level active before this edge; a same-edge push
    // always targets a strictly higher level, so the two never collide.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_eff && w_wr_banked) begin
            r_bank[w_cur_level][bus.writeAddr] <= bus.writeData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < N_LEVELS; l++) r_valid[l] <= '0;
        end else begin
            if (w_wr_eff && w_wr_banked) r_valid[w_cur_level][bus.writeAddr] <= 1'b1;
            if (w_inv_strobe)            r_valid[w_inv_level] <= '0;
        end
    end

    function automatic reg_t read_port(input reg_addr_t addr);
        reg_t data;
        if (BYPASS && w_wr_eff && (addr == bus.writeAddr)) begin
            data = bus.writeData;
        end else if (addr == REG_ZERO) begin
            data = '0;
        end else if (BANK_MASK[addr]) begin
            if (r_valid[w_cur_level][addr]) data = r_bank[w_cur_level][addr];
            else if (addr == REG_RA)         data = RA_INIT;
            else                             data = '0;
        end else begin
            data = r_shared[addr];
        end
        return data;
    endfunction

    always_comb begin
        bus.readData1 = read_port(bus.readAddr1);
        bus.readData2 = read_port(bus.readAddr2);
    end
endmodule
`default_nettype wire

// File: tb/tb_rf_stack_nested.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_stack_nested
// Description : Self-checking bench; drives a non-bypass and a bypass build
//               with identical stimulus against a behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_rf_stack_nested;
    import rf_stack_nested_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push, pop, wr_en, ra_en;
    logic [2:0]  prio;
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rf_stack_nested_if bus0 ();
    rf_stack_nested_if bus1 ();

    assign bus0.levelPush = push;   assign bus1.levelPush = push;
    assign bus0.levelPushPrio = prio; assign bus1.levelPushPrio = prio;
    assign bus0.levelPop = pop;     assign bus1.levelPop = pop;
    assign bus0.writeEn = wr_en;    assign bus1.writeEn = wr_en;
    assign bus0.writeRaEn = ra_en;  assign bus1.writeRaEn = ra_en;
    assign bus0.writeAddr = wa;     assign bus1.writeAddr = wa;
    assign bus0.writeData = wd;     assign bus1.writeData = wd;
    assign bus0.readAddr1 = ra1;    assign bus1.readAddr1 = ra1;
    assign bus0.readAddr2 = ra2;    assign bus1.readAddr2 = ra2;

    rf_stack_nested #(.BYPASS(1'b0)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
    rf_stack_nested #(.BYPASS(1'b1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

    // Behavioural model: register contents per level plus a queue for the stack.
    logic [31:0] m_shared [32];
    logic [31:0] m_bank   [8][32];
    bit          m_valid  [8][32];
    int          m_stack  [$];
    int          m_cur;
    bit          m_err;

    function automatic bit write_effective();
        return wr_en && (wa != 5'd0) && ((wa != 5'd1) || ra_en);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit bp);
        if (bp && write_effective() && a == wa) return wd;
        if (a == 5'd0) return 32'h0;
        if (BANK_MASK[a]) begin
            if (m_valid[m_cur][a]) return m_bank[m_cur][a];
            return (a == 5'd1) ? 32'hFFFF_FFFF : 32'h0;
        end
        return m_shared[a];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_shared[r] = 32'h0;
        for (int l = 0; l < 8; l++) for (int r = 0; r < 32; r++) m_valid[l][r] = 1'b0;
        m_stack.delete();
        m_cur = 0;
        m_err = 1'b0;
    endtask

    task automatic idle();
        push = 0; pop = 0; prio = 0; wr_en = 0; ra_en = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0;
    endtask

    task automatic tick();
        bit we;
        we = write_effective();
        @(posedge clk); #1;
        if (rst) begin
            model_reset();
        end else begin
            if (we) begin
                if (BANK_MASK[wa]) begin
                    m_bank[m_cur][wa] = wd;
                    m_valid[m_cur][wa] = 1'b1;
                end else begin
                    m_shared[wa] = wd;
                end
            end
            m_err = 1'b0;
            if (push && pop) begin
                m_err = 1'b1;
            end else if (push) begin
                if (int'(prio) > m_cur && m_stack.size() < 7) begin
                    m_stack.push_back(m_cur);
                    m_cur = int'(prio);
                    for (int r = 0; r < 32; r++) m_valid[m_cur][r] = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end else if (pop) begin
                if (m_stack.size() > 0) m_cur = m_stack.pop_back();
                else m_err = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
        vectors += 3;
        if (bus0.curLevel !== 3'd0) begin miscompares++; $display("FAIL reset_cur: got %0d want 0", bus0.curLevel); end
        if (bus0.depth !== 3'd0) begin miscompares++; $display("FAIL reset_depth: got %0d want 0", bus0.depth); end
        if (bus0.levelErr !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", bus0.levelErr); end
        ra1 = 5'd5; ra2 = 5'd1; #1;
        vectors += 3;
        if (bus0.readData1 !== 32'h0) begin miscompares++; $display("FAIL reset_x5: got %h want 0", bus0.readData1); end
        if (bus0.readData2 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset_ra0: got %h want ffffffff", bus0.readData2); end
        if (bus1.readData2 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset_ra1: got %h want ffffffff", bus1.readData2); end
    endtask

    task automatic test_shared_regs();
        idle(); wr_en = 1; wa = REG_SP; wd = 32'h1234_5678; tick();
        idle(); push = 1; prio = 3'd2; tick();
        idle(); ra1 = REG_SP; ra2 = 5'd0; #1;
        vectors += 3;
        if (bus0.curLevel !== 3'd2) begin miscompares++; $display("FAIL shared_cur: got %0d want 2", bus0.curLevel); end
        if (bus0.readData1 !== 32'h1234_5678) begin miscompares++; $display("FAIL shared_sp: got %h want 12345678", bus0.readData1); end
        if (bus0.readData2 !== 32'h0) begin miscompares++; $display("FAIL shared_x0: got %h want 0", bus0.readData2); end
    endtask

    task automatic test_banked_isolation();
        idle(); pop = 1; tick();
        idle(); push = 1; prio = 3'd1; tick();
        idle(); wr_en = 1; wa = 5'd31; wd = 32'hAAAA_0000; tick();
        idle(); push = 1; prio = 3'd3; tick();
        idle(); ra1 = 5'd31; ra2 = 5'd1; #1;
        vectors += 2;
        if (bus0.readData1 !== 32'h0) begin miscompares++; $display("FAIL bank_x31_l3: got %h want 0", bus0.readData1); end
        if (bus0.readData2 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL bank_ra_l3: got %h want ffffffff", bus0.readData2); end
        idle(); pop = 1; tick();
        idle(); ra1 = 5'd31; #1;
        vectors += 2;
        if (bus0.curLevel !== 3'd1) begin miscompares++; $display("FAIL bank_pop_cur: got %0d want 1", bus0.curLevel); end
        if (bus0.readData1 !== 32'hAAAA_0000) begin miscompares++; $display("FAIL bank_x31_l1: got %h want aaaa0000", bus0.readData1); end
    endtask

    task automatic test_ra_write();
        idle(); pop = 1; tick();
        idle(); push = 1; prio = 3'd2; tick();
        idle(); wr_en = 1; ra_en = 0; wa = REG_RA; wd = 32'h0000_FFFF; tick();
        idle(); ra1 = REG_RA; #1;
        vectors++;
        if (bus0.readData1 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL ra_dropped: got %h want ffffffff", bus0.readData1); end
        idle(); wr_en = 1; ra_en = 1; wa = REG_RA; wd = 32'h0000_FFFF; tick();
        idle(); ra1 = REG_RA; #1;
        vectors++;
        if (bus0.readData1 !== 32'h0000_FFFF) begin miscompares++; $display("FAIL ra_written: got %h want 0000ffff", bus0.readData1); end
    endtask

    task automatic test_stale_invalidate();
        idle(); push = 1; prio = 3'd5; tick();
        idle(); wr_en = 1; wa = 5'd31; wd = 32'h55; tick();
        idle(); ra1 = 5'd31; #1;
        vectors++;
        if (bus0.readData1 !== 32'h55) begin miscompares++; $display("FAIL stale_first: got %h want 55", bus0.readData1); end
        idle(); pop = 1; tick();
        idle(); push = 1; prio = 3'd5; tick();
        idle(); ra1 = 5'd31; #1;
        vectors += 2;
        if (bus0.curLevel !== 3'd5) begin miscompares++; $display("FAIL stale_cur: got %0d want 5", bus0.curLevel); end
        if (bus0.readData1 !== 32'h0) begin miscompares++; $display("FAIL stale_x31: got %h want 0", bus0.readData1); end
    endtask

    task automatic test_bad_push();
        idle(); pop = 1; tick();
        idle(); push = 1; prio = 3'd3; tick();
        idle(); push = 1; prio = 3'd1; tick();
        vectors += 3;
        if (bus0.levelErr !== 1'b1) begin miscompares++; $display("FAIL badpush_err: got %b want 1", bus0.levelErr); end
        if (bus0.curLevel !== 3'd3) begin miscompares++; $display("FAIL badpush_cur: got %0d want 3", bus0.curLevel); end
        if (bus0.depth !== 3'd2) begin miscompares++; $display("FAIL badpush_depth: got %0d want 2", bus0.depth); end
        idle(); tick();
        vectors++;
        if (bus0.levelErr !== 1'b0) begin miscompares++; $display("FAIL badpush_pulse: got %b want 0", bus0.levelErr); end
    endtask

    task automatic test_stack_limits();
        idle(); rst = 1; tick(); rst = 0;
        idle(); pop = 1; tick();
        vectors += 2;
        if (bus0.levelErr !== 1'b1) begin miscompares++; $display("FAIL underflow_err: got %b want 1", bus0.levelErr); end
        if (bus0.depth !== 3'd0) begin miscompares++; $display("FAIL underflow_depth: got %0d want 0", bus0.depth); end
        for (int i = 1; i <= 7; i++) begin
            idle(); push = 1; prio = 3'(i); tick();
            vectors += 3;
            if (bus0.levelErr !== 1'b0) begin miscompares++; $display("FAIL nest%0d_err: got %b want 0", i, bus0.levelErr); end
            if (bus0.curLevel !== 3'(i)) begin miscompares++; $display("FAIL nest%0d_cur: got %0d want %0d", i, bus0.curLevel, i); end
            if (bus0.depth !== 3'(i)) begin miscompares++; $display("FAIL nest%0d_depth: got %0d want %0d", i, bus0.depth, i); end
        end
        idle(); push = 1; prio = 3'd7; tick();
        vectors += 2;
        if (bus0.levelErr !== 1'b1) begin miscompares++; $display("FAIL overflow_err: got %b want 1", bus0.levelErr); end
        if (bus0.depth !== 3'd7) begin miscompares++; $display("FAIL overflow_depth: got %0d want 7", bus0.depth); end
        idle(); pop = 1; tick();
        idle(); push = 1; prio = 3'd7; pop = 1; tick();
        vectors += 3;
        if (bus0.levelErr !== 1'b1) begin miscompares++; $display("FAIL pushpop_err: got %b want 1", bus0.levelErr); end
        if (bus0.curLevel !== 3'd6) begin miscompares++; $display("FAIL pushpop_cur: got %0d want 6", bus0.curLevel); end
        if (bus0.depth !== 3'd6) begin miscompares++; $display("FAIL pushpop_depth: got %0d want 6", bus0.depth); end
    endtask

    task automatic test_bypass();
        idle(); wr_en = 1; wa = 5'd5; wd = 32'h0000_DEAD; ra1 = 5'd5; #1;
        vectors += 2;
        if (bus1.readData1 !== 32'h0000_DEAD) begin miscompares++; $display("FAIL bypass_on: got %h want 0000dead", bus1.readData1); end
        if (bus0.readData1 !== 32'h0) begin miscompares++; $display("FAIL bypass_off: got %h want 0", bus0.readData1); end
        tick();
        idle(); ra1 = 5'd5; #1;
        vectors++;
        if (bus0.readData1 !== 32'h0000_DEAD) begin miscompares++; $display("FAIL bypass_after: got %h want 0000dead", bus0.readData1); end
    endtask

    // Push with a simultaneous write: the write must stay in the old level.
    task automatic test_write_with_push();
        idle(); pop = 1; tick();
        idle(); wr_en = 1; wa = 5'd9; wd = 32'h0BAD_F00D; push = 1; prio = 3'd7; tick();
        idle(); ra1 = 5'd9; #1;
        vectors++;
        if (bus0.readData1 !== 32'h0) begin miscompares++; $display("FAIL wpush_new: got %h want 0", bus0.readData1); end
        idle(); pop = 1; tick();
        idle(); ra1 = 5'd9; #1;
        vectors++;
        if (bus0.readData1 !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL wpush_old: got %h want 0badf00d", bus0.readData1); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int n = 0; n < 600; n++) begin
            idle();
            rst   = ($urandom_range(199, 0) == 0);
            push  = ($urandom_range(99, 0) < 18);
            pop   = ($urandom_range(99, 0) < 15);
            prio  = 3'($urandom_range(7, 0));
            wr_en = ($urandom_range(99, 0) < 60);
            ra_en = $urandom_range(1, 0) != 0;
            wa    = 5'($urandom_range(31, 0));
            wd    = $urandom;
            ra1   = ($urandom_range(3, 0) == 0) ? wa : 5'($urandom_range(31, 0));
            ra2   = 5'($urandom_range(7, 0));
            #1;
            e = exp_read(ra1, 1'b0); vectors++;
            if (bus0.readData1 !== e) begin miscompares++; $display("FAIL rnd%0d_rd1: got %h want %h", n, bus0.readData1, e); end
            e = exp_read(ra2, 1'b0); vectors++;
            if (bus0.readData2 !== e) begin miscompares++; $display("FAIL rnd%0d_rd2: got %h want %h", n, bus0.readData2, e); end
            e = exp_read(ra1, 1'b1); vectors++;
            if (bus1.readData1 !== e) begin miscompares++; $display("FAIL rnd%0d_bp_rd1: got %h want %h", n, bus1.readData1, e); end
            e = exp_read(ra2, 1'b1); vectors++;
            if (bus1.readData2 !== e) begin miscompares++; $display("FAIL rnd%0d_bp_rd2: got %h want %h", n, bus1.readData2, e); end
            tick();
            vectors += 4;
            if (bus0.curLevel !== 3'(m_cur)) begin miscompares++; $display("FAIL rnd%0d_cur: got %0d want %0d", n, bus0.curLevel, m_cur); end
            if (bus0.depth !== 3'(m_stack.size())) begin miscompares++; $display("FAIL rnd%0d_depth: got %0d want %0d", n, bus0.depth, m_stack.size()); end
            if (bus0.levelErr !== m_err) begin miscompares++; $display("FAIL rnd%0d_err: got %b want %b", n, bus0.levelErr, m_err); end
            if (bus1.curLevel !== 3'(m_cur)) begin miscompares++; $display("FAIL rnd%0d_bp_cur: got %0d want %0d", n, bus1.curLevel, m_cur); end
        end
        rst = 0;
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_shared_regs();
        test_banked_isolation();
        test_ra_write();
        test_stale_invalidate();
        test_bad_push();
        test_stack_limits();
        test_bypass();
        test_write_with_push();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rf_stack_nested.md
Name: rf_stack_nested

Overview:
- Parametrised successor to the level-banked register file: N priority levels, a per-register banking mask, and an internal level stack that tracks nested preemption.
- Level changes are requested by push/pop pulses from the interrupt controller rather than driven as a raw `level` input.
- Banked registers of a newly entered level are lazily invalidated in one cycle, with no copy cycles.
- Sits in the core between decode/writeback and the interrupt controller; replaces direct level steering of the register file.

Parameters:
- NLevels, 8: number of priority levels (level 0 = thread mode); power of two, ≥2.
- RegWidth, 32: data width.
- NRegs, 32: architectural registers.
- BankMask, 32'hFFFF_FFE2: bit i = 1 means register i is banked per level. x0, sp, gp and tp are shared; ra and the rest are banked.
- RaInit, 32'hFFFF_FFFF: value read from an invalid banked ra (hardware return marker).
- Bypass, 0: 1 = same-cycle write-to-read forwarding.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- levelPush  in  1  enter level levelPushPrio at next edge
- levelPushPrio  in  PrioT  requested level
- levelPop  in  1  return to preempted level at next edge
- curLevel  out  PrioT  active level
- depth  out  PrioT  nesting depth (0 = thread mode)
- levelErr  out  1  one-cycle pulse: rejected push/pop
- writeEn  in  1  write enable
- writeRaEn  in  1  qualifies writes to ra (x1)
- writeAddr  in  RegAddrT  write address
- writeData  in  RegT  write data
- readAddr1, readAddr2  in  RegAddrT  read addresses
- readData1, readData2  out  RegT  combinational read data

Behaviour:
- Reset:
  - curLevel=0, depth=0, levelErr=0.
  - All valid bits cleared for all levels.
  - Shared registers reset to 0.
  - Reads after reset: x0=0; invalid banked ra=RaInit; other invalid banked regs=0.
- Storage:
  - Shared regs: one copy each.
  - Banked regs: NLevels copies each, plus a valid bit per (level, reg).
- Read (combinational, current curLevel):
  - x0 always reads 0.
  - Banked+valid returns the stored value; banked+invalid returns RaInit for ra, 0 otherwise.
  - With Bypass=1, readAddr==writeAddr during an effective write returns writeData.
  - With Bypass=0, read data is the pre-edge value.
- Write (posedge, into curLevel's bank before any level change that edge):
  - Effective when writeEn=1 and writeAddr≠0.
  - For ra, additionally requires writeRaEn=1; otherwise the write is silently dropped.
  - A banked write sets its valid bit.
- Level stack: NLevels−1 entries of PrioT.
  - Push is accepted iff levelPushPrio > curLevel and depth < NLevels−1. On accept:
    - curLevel is pushed onto the stack.
    - curLevel ← levelPushPrio, depth+1.
    - All valid bits of the new level are cleared.
  - Pop is accepted iff depth > 0. On accept:
    - curLevel ← stack top, depth−1.
    - Contents and valid bits of the popped level are not cleared; they are invalidated at next entry.
  - A rejected push (prio ≤ curLevel or full) or pop (empty) pulses levelErr; state is unchanged.
  - levelPush and levelPop in the same cycle: both ignored, levelErr pulses.
- Simultaneous write and push: the write lands in the old level; the new level is invalidated. The write is never lost or misdirected.
- Reset mid-nesting: returns to level 0 and depth 0, and invalidates all banks.
- Latency: level changes are visible on curLevel and read data the cycle after the edge. No stall or busy output.

Decomposition:
- config_pkg additions:
  - NLevels, PrioT = logic[$clog2(NLevels)-1:0], BankMask, RaInit.
  - Existing RegT and RegAddrT.
  - Existing named registers Zero, Ra, Sp.
- One sub-module: level_stack. It holds push/pop validation, the stack array, depth, curLevel and levelErr, and drives an invalidate strobe plus target level to the register array.

Test Plan:
- Reset, level 0: write Sp=0x12345678, push to 2 → readData on Sp = 0x12345678 at level 2; Zero reads 0.
- Level 1: write x31=0xAAAA_0000, push 3 → x31 reads 0, ra reads 0xFFFF_FFFF; pop → x31 = 0xAAAA_0000.
- Level 2: writeEn=1, writeRaEn=0, Ra, 0x0000_FFFF → ra still 0xFFFF_FFFF; repeat with writeRaEn=1 → 0x0000_FFFF.
- Push 5 with level 5 holding stale x31=0x55 from an earlier visit → x31 reads 0, valid bits cleared.
- Push 1 while at level 3 → levelErr=1 for one cycle, curLevel stays 3.
- Pop at depth 0 → levelErr=1; 7 nested pushes at NLevels=8 followed by an 8th → overflow error; push+pop in the same cycle → error, no change.
- Bypass=1 build: write x5=0xDEAD with readAddr1=5 in the same cycle → readData1=0xDEAD combinationally; Bypass=0 → old value.
